coe_load_controller: RTL and testbench
======================================

# coe_load_controller

Sequencing controller for the UART COE programming session that refills instruction and data memory. It owns the UART programmer reset and the CPU reset, and routes each programmer write to instruction memory or data memory by address bit 14. It counts the words loaded per memory, detects a stalled transfer by timeout, and releases the CPU only after a clean finish. It sits between the UART programmer IP, whose outputs are already retimed into the `iFpgaClock` domain, and the two memory write ports.

## Interface
- `TIMEOUT_CYCLES`, default 100000000: idle cycles allowed in LOAD with no write before ERROR (1 s at 100 MHz); minimum 2.
- `RELEASE_DELAY`, default 16: cycles spent in DRAIN between `iUpgDone` and CPU release; minimum 1.

- `iFpgaClock` in 1: the single clock, 100 MHz.
- `iFpgaReset` in 1: reset, synchronous, active-high.
- `iStartReceiveCoe` in 1: start request, level, debounced; only its rising edge acts.
- `iUpgWriteEnable` in 1: programmer write strobe.
- `iUpgAddress` in 15: programmer word address; bit 14 = 1 selects DM.
- `iUpgData` in 32: programmer write data.
- `iUpgDone` in 1: programmer finished the transfer.
- `oUpgReset` out 1: reset to the programmer IP; 0 only in LOAD and DRAIN.
- `oCpuReset` out 1: CPU hold; 0 only in RUN.
- `oImWriteEnable` out 1: one-cycle IM write strobe.
- `oDmWriteEnable` out 1: one-cycle DM write strobe.
- `oWriteAddress` out 14: registered `iUpgAddress[13:0]`.
- `oWriteData` out 32: registered `iUpgData`.
- `oImWordCount` out 15: IM writes in the current or last session.
- `oDmWordCount` out 15: DM writes in the current or last session.
- `oLoadBusy` out 1: high in LOAD and DRAIN.
- `oLoadDone` out 1: sticky; last session completed.
- `oLoadError` out 1: sticky; last session timed out.

## Operation
- **States:** RUN, LOAD, DRAIN, ERROR. Reset enters RUN.
- **Start edge:** start = `iStartReceiveCoe` & !previous sample.
  - In RUN or ERROR, a start edge moves the block to LOAD. It clears both word counts, the timeout counter, `oLoadDone` and `oLoadError`.
  - In LOAD or DRAIN, start edges are ignored.
- **LOAD:** `oUpgReset`=0, `oCpuReset`=1, `oLoadBusy`=1.
  - Each sampled `iUpgWriteEnable`=1 produces exactly one strobe: `oImWriteEnable` if `iUpgAddress[14]`=0, `oDmWriteEnable` if it is 1. Never both at once.
  - The same edge registers address and data, and increments the matching word count. Counts saturate at 32767.
  - Timeout counter: cleared on every write and counts every LOAD cycle without one. When it reaches `TIMEOUT_CYCLES`-1 with no write and no done, the block goes to ERROR.
- **Done:** `iUpgDone`=1 in LOAD moves the block to DRAIN. Done takes priority over timeout. A write sampled on the same edge is still forwarded and counted.
- **DRAIN:** outputs as in LOAD, but programmer writes are blocked (no strobes, no counting). After `RELEASE_DELAY` cycles the block goes to RUN and sets `oLoadDone`=1.
- **RUN:** `oUpgReset`=1, `oCpuReset`=0, `oLoadBusy`=0, strobes blocked.
- **ERROR:** `oUpgReset`=1, `oCpuReset`=1, `oLoadError`=1, strobes blocked. The only exits are a start edge or `iFpgaReset`.
- **Write data path:** `oWriteAddress` and `oWriteData` hold their last value when no write occurs.

## Timing
- All outputs are registered.
- **Reset values:** `oUpgReset`=1, `oCpuReset`=1, strobes 0, address/data 0, counts 0, `oLoadBusy`/`oLoadDone`/`oLoadError`=0, previous-start sample 0.
- `oCpuReset` drops to 0 on the first edge after reset deasserts (state RUN).
- **Reset mid-operation:** `iFpgaReset` wins over every event on the same edge, including in LOAD or DRAIN. The session is abandoned, state returns to RUN and all reset values apply.
- **Start latency:** start first sampled high at edge N gives LOAD outputs valid after edge N.
- **Write latency 1:** write sampled at edge N gives strobe, address, data and incremented count valid after edge N, for one cycle.
- **Done:** done sampled at edge N gives DRAIN after edge N and RUN after edge N+`RELEASE_DELAY`.
- **Timeout:** ERROR is entered exactly `TIMEOUT_CYCLES` cycles after the last write, or after LOAD entry if no write has occurred.

## Test plan
Bench parameters: `TIMEOUT_CYCLES`=64, `RELEASE_DELAY`=4.
- **Reset/idle:** hold `iFpgaReset` 3 cycles -> during reset `oCpuReset`=1 and `oUpgReset`=1; one cycle after release `oCpuReset`=0, counts 0, all flags 0.
- **Mixed load:** start, write addr 0x0000/0xDEADBEEF, then 0x4003/0x12345678, then done -> `oImWriteEnable` with `oWriteAddress`=0x0000, then `oDmWriteEnable` with 0x0003 and data 0x12345678; counts IM=1, DM=1; `oCpuReset` falls 4 cycles after done; `oLoadDone`=1.
- **Timeout:** start, one write, then 64 idle cycles -> ERROR 64 cycles after the write: `oLoadError`=1, `oCpuReset`=1, `oUpgReset`=1; a new start edge clears the error and re-enters LOAD.
- **Simultaneous events:** write to 0x4000 and done on the same edge -> the DM strobe still fires and DM count=1; a write during DRAIN produces no strobe; a start edge during LOAD has no effect.
- **Reset mid-load:** start, 5 IM writes, then assert `iFpgaReset` -> counts return to 0, state RUN, `oUpgReset`=1, no strobes.
- **Held start:** keep `iStartReceiveCoe` high through a completed session -> exactly one session; no re-entry to LOAD until the input falls and rises again.

Source files
------------

// File: rtl/coe_load_controller.sv
// Sequences a UART COE reload: holds the CPU in reset and routes programmer writes to IM or DM.
// It releases the CPU after a clean finish, or parks in ERROR when the transfer stalls.
module coe_load_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned RELEASE_DELAY  = 16
) (
  input  logic        iFpgaClock,
  input  logic        iFpgaReset,
  input  logic        iStartReceiveCoe,
  input  logic        iUpgWriteEnable,
  input  logic [14:0] iUpgAddress,
  input  logic [31:0] iUpgData,
  input  logic        iUpgDone,
  output logic        oUpgReset,
  output logic        oCpuReset,
  output logic        oImWriteEnable,
  output logic        oDmWriteEnable,
  output logic [13:0] oWriteAddress,
  output logic [31:0] oWriteData,
  output logic [14:0] oImWordCount,
  output logic [14:0] oDmWordCount,
  output logic        oLoadBusy,
  output logic        oLoadDone,
  output logic        oLoadError
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int DW = $clog2(RELEASE_DELAY) + 1;
  localparam logic [14:0] COUNT_MAX = 15'h7FFF;

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_DRAIN, ST_ERROR} state_e;

  state_e          state_q, state_d;
  logic            start_prev_q;
  logic [TW-1:0]   timer_q;
  logic [DW-1:0]   drain_q;
  logic            start_edge;
  logic            load_write;
  logic            timeout_hit;
  logic            next_busy;

  assign start_edge  = iStartReceiveCoe & ~start_prev_q;
  assign load_write  = (state_q == ST_LOAD) & iUpgWriteEnable;
  // Done outranks timeout, and any write in the same cycle restarts the idle window.
  assign timeout_hit = (state_q == ST_LOAD) & ~iUpgWriteEnable & ~iUpgDone &
                       (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_ERROR: if (start_edge) state_d = ST_LOAD;
      ST_LOAD: begin
        if (iUpgDone)         state_d = ST_DRAIN;
        else if (timeout_hit) state_d = ST_ERROR;
      end
      ST_DRAIN: if (drain_q == DW'(RELEASE_DELAY - 1)) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign next_busy = (state_d == ST_LOAD) | (state_d == ST_DRAIN);

  always_ff @(posedge iFpgaClock) begin
    if (iFpgaReset) begin
      state_q        <= ST_RUN;
      start_prev_q   <= 1'b0;
      timer_q        <= '0;
      drain_q        <= '0;
      oUpgReset      <= 1'b1;
      oCpuReset      <= 1'b1;
      oImWriteEnable <= 1'b0;
      oDmWriteEnable <= 1'b0;
      oWriteAddress  <= '0;
      oWriteData     <= '0;
      oImWordCount   <= '0;
      oDmWordCount   <= '0;
      oLoadBusy      <= 1'b0;
      oLoadDone      <= 1'b0;
      oLoadError     <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= iStartReceiveCoe;
      oUpgReset      <= ~next_busy;
      oCpuReset      <= (state_d != ST_RUN);
      oLoadBusy      <= next_busy;
      oImWriteEnable <= load_write & ~iUpgAddress[14];
      oDmWriteEnable <= load_write & iUpgAddress[14];

      if (state_q != ST_LOAD || load_write) timer_q <= '0;
      else                                  timer_q <= timer_q + 1'b1;

      if (state_q != ST_DRAIN) drain_q <= '0;
      else                     drain_q <= drain_q + 1'b1;

      if ((state_q == ST_RUN || state_q == ST_ERROR) && start_edge) begin
        oImWordCount <= '0;
        oDmWordCount <= '0;
        oLoadDone    <= 1'b0;
        oLoadError   <= 1'b0;
      end

      if (load_write) begin
        oWriteAddress <= iUpgAddress[13:0];
        oWriteData    <= iUpgData;
        if (iUpgAddress[14]) begin
          if (oDmWordCount != COUNT_MAX) oDmWordCount <= oDmWordCount + 1'b1;
        end else begin
          if (oImWordCount != COUNT_MAX) oImWordCount <= oImWordCount + 1'b1;
        end
      end

      if (state_q == ST_DRAIN && state_d == ST_RUN) oLoadDone  <= 1'b1;
      if (state_q == ST_LOAD && state_d == ST_ERROR) oLoadError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_coe_load_controller.sv
// Directed and randomized bench for coe_load_controller, checked every cycle against a
// cycle-stamp model of the session rules (timeouts and release as absolute deadlines).
module tb_coe_load_controller;
  localparam int T = 64;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        srst, start, we, done;
  logic [14:0] addr;
  logic [31:0] data;
  logic        upg_rst, cpu_rst, im_we, dm_we, busy, ldone, lerr;
  logic [13:0] waddr;
  logic [31:0] wdata;
  logic [14:0] imc, dmc;

  int compared = 0;
  int mismatched = 0;

  coe_load_controller #(.TIMEOUT_CYCLES(T), .RELEASE_DELAY(R)) dut (
    .iFpgaClock(clk), .iFpgaReset(srst), .iStartReceiveCoe(start),
    .iUpgWriteEnable(we), .iUpgAddress(addr), .iUpgData(data), .iUpgDone(done),
    .oUpgReset(upg_rst), .oCpuReset(cpu_rst), .oImWriteEnable(im_we),
    .oDmWriteEnable(dm_we), .oWriteAddress(waddr), .oWriteData(wdata),
    .oImWordCount(imc), .oDmWordCount(dmc), .oLoadBusy(busy),
    .oLoadDone(ldone), .oLoadError(lerr)
  );

  always #5 clk = ~clk;

  // Reference model: session mode plus absolute cycle stamps for deadlines.
  typedef enum {M_RUN, M_LOAD, M_DRAIN, M_ERR} mode_t;
  mode_t       m_mode = M_RUN;
  int          m_cyc = 0, m_last = 0, m_release = 0;
  logic        m_prev = 1'b0;
  logic        e_upg, e_cpu, e_im, e_dm, e_busy, e_done, e_err;
  logic [13:0] e_addr;
  logic [31:0] e_data;
  logic [14:0] e_imc, e_dmc;

  task automatic model_edge();
    logic st_edge;
    m_cyc++;
    if (srst) begin
      m_mode = M_RUN; m_prev = 1'b0;
      e_upg = 1; e_cpu = 1; e_im = 0; e_dm = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_addr = 0; e_data = 0; e_imc = 0; e_dmc = 0;
      return;
    end
    st_edge = start && !m_prev;
    m_prev  = start;
    e_im = 0; e_dm = 0;
    case (m_mode)
      M_RUN, M_ERR: if (st_edge) begin
        m_mode = M_LOAD; e_imc = 0; e_dmc = 0; e_done = 0; e_err = 0; m_last = m_cyc;
      end
      M_LOAD: begin
        if (we) begin
          if (addr[14]) begin e_dm = 1; if (e_dmc != 15'h7FFF) e_dmc = e_dmc + 1; end
          else          begin e_im = 1; if (e_imc != 15'h7FFF) e_imc = e_imc + 1; end
          e_addr = addr[13:0]; e_data = data; m_last = m_cyc;
        end
        if (done) begin m_mode = M_DRAIN; m_release = m_cyc + R; end
        else if (!we && (m_cyc - m_last) >= T) begin m_mode = M_ERR; e_err = 1; end
      end
      M_DRAIN: if (m_cyc >= m_release) begin m_mode = M_RUN; e_done = 1; end
      default: m_mode = M_RUN;
    endcase
    e_busy = (m_mode == M_LOAD) || (m_mode == M_DRAIN);
    e_upg  = !e_busy;
    e_cpu  = (m_mode != M_RUN);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".upg_rst"}, 32'(upg_rst), 32'(e_upg));
    chk({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(e_cpu));
    chk({tag, ".im_we"},   32'(im_we),   32'(e_im));
    chk({tag, ".dm_we"},   32'(dm_we),   32'(e_dm));
    chk({tag, ".waddr"},   32'(waddr),   32'(e_addr));
    chk({tag, ".wdata"},   wdata,        e_data);
    chk({tag, ".imc"},     32'(imc),     32'(e_imc));
    chk({tag, ".dmc"},     32'(dmc),     32'(e_dmc));
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    chk({tag, ".done"},    32'(ldone),   32'(e_done));
    chk({tag, ".err"},     32'(lerr),    32'(e_err));
  endtask

  task automatic idle();
    we = 0; done = 0; addr = 15'($urandom); data = $urandom;
  endtask

  task automatic wr(logic [14:0] a, logic [31:0] d);
    we = 1; addr = a; data = d;
  endtask

  task automatic pulse_start(string tag);
    start = 1; step(tag);
    start = 0;
  endtask

  initial begin
    srst = 1; start = 0; idle();

    // Reset held 3 cycles, then one cycle of release
    repeat (3) step("reset");
    chk("reset.cpu_held", 32'(cpu_rst), 32'd1);
    srst = 0; step("release");
    chk("release.cpu_run", 32'(cpu_rst), 32'd0);

    // Mixed IM/DM load
    pulse_start("mix.start");
    chk("mix.busy", 32'(busy), 32'd1);
    wr(15'h0000, 32'hDEADBEEF); step("mix.wr_im");
    chk("mix.im_strobe", 32'(im_we), 32'd1);
    wr(15'h4003, 32'h12345678); step("mix.wr_dm");
    chk("mix.dm_addr", 32'(waddr), 32'h0003);
    chk("mix.dm_data", wdata, 32'h12345678);
    idle(); done = 1; step("mix.done");
    done = 0;
    repeat (R - 1) step("mix.drain");
    chk("mix.cpu_held", 32'(cpu_rst), 32'd1);
    step("mix.release");
    chk("mix.cpu_free", 32'(cpu_rst), 32'd0);
    chk("mix.load_done", 32'(ldone), 32'd1);

    // Timeout: one write then T idle cycles
    pulse_start("to.start");
    wr(15'h0010, $urandom); step("to.wr");
    idle();
    repeat (T - 1) step("to.idle");
    chk("to.not_yet", 32'(lerr), 32'd0);
    step("to.expire");
    chk("to.error", 32'(lerr), 32'd1);
    repeat (3) step("to.parked");
    pulse_start("to.restart");
    chk("to.err_cleared", 32'(lerr), 32'd0);
    done = 1; step("to.done");
    done = 0;
    repeat (R + 1) step("to.drain");

    // Simultaneous write+done, write during DRAIN, start edge during LOAD
    pulse_start("sim.start");
    wr(15'h0001, $urandom); start = 1; step("sim.start_in_load");
    start = 0;
    wr(15'h4000, $urandom); done = 1; step("sim.wr_done");
    chk("sim.dm_strobe", 32'(dm_we), 32'd1);
    done = 0; wr(15'h0005, $urandom); step("sim.wr_drain");
    chk("sim.drain_no_strobe", 32'(im_we), 32'd0);
    idle();
    repeat (R) step("sim.drain");

    // Reset in the middle of a load
    pulse_start("mid.start");
    for (int i = 0; i < 5; i++) begin wr(15'(i), $urandom); step("mid.wr"); end
    idle(); srst = 1; step("mid.reset");
    chk("mid.imc_cleared", 32'(imc), 32'd0);
    srst = 0; step("mid.release");

    // Start held high for a whole session: exactly one session
    start = 1; step("held.start");
    for (int i = 0; i < 3; i++) begin wr(15'($urandom), $urandom); step("held.wr"); end
    idle(); done = 1; step("held.done");
    done = 0;
    repeat (R + 6) step("held.hold");
    chk("held.no_reentry", 32'(busy), 32'd0);
    start = 0; step("held.fall");
    pulse_start("held.rise");
    chk("held.reentry", 32'(busy), 32'd1);

    // Randomized traffic with an idle window long enough to time out
    for (int i = 0; i < 400; i++) begin
      srst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 11) == 0) start = ~start;
      we   = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 39) == 0);
      addr = 15'($urandom);
      data = $urandom;
      if (i >= 150 && i < 240) begin we = 0; done = 0; srst = 0; end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
